// File: rtl/hht_pkg.sv
// Shared types and sizing for the HHT sparse-matrix gather front-end.
package hht_pkg;

  localparam int DW         = 32;
  localparam int V_SIZE_DEF = 9;

  typedef logic [DW-1:0] data_t;
  typedef logic [DW-1:0] addr_t;

endpackage

// File: rtl/hht_control_if.sv
// Bundle of configuration, memory and consumer signals around hht_control.
// The gather engine takes the master side; memories and the consumer take the slave side.
interface hht_control_if;
  import hht_pkg::*;

  addr_t v_values_base;
  addr_t wdata_col_base;
  data_t csize;
  addr_t addr1;
  addr_t addr2;
  data_t dataIn1;
  data_t dataIn2;
  logic  RD;
  data_t dataOut;
  logic  valid;
  logic  full;
  logic  done;

  modport master (
    input  v_values_base, wdata_col_base, csize, dataIn1, dataIn2, RD,
    output addr1, addr2, dataOut, valid, full, done
  );

  modport slave (
    output v_values_base, wdata_col_base, csize, dataIn1, dataIn2, RD,
    input  addr1, addr2, dataOut, valid, full, done
  );

endinterface

// File: rtl/hht_vfifo.sv
// Synchronous FIFO holding gathered vector values; depth need not be a power of two.
module hht_vfifo #(
  parameter  int DEPTH = 9,
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign data_out = empty ? '0 : mem_q[rd_ptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/hht_control.sv
// Gather front-end: streams column indices, fetches the matching vector values,
// and queues them for the multiply/accumulate consumer.
module hht_control
  import hht_pkg::*;
#(
  parameter int V_SIZE = V_SIZE_DEF
) (
  input  logic          Clk,
  input  logic          Rst,
  hht_control_if.master bus
);

  localparam int CW = $clog2(V_SIZE + 1);

  data_t         idx_q, idx_d;
  data_t         col_reg_q, col_reg_d;
  logic          col_vld_q, col_vld_d;
  logic          done_q, done_d;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  data_t         credit_used;
  logic          issue;

  // The in-flight stage entry already owns a FIFO slot; a same-cycle pop is
  // deliberately not credited, so issue resumes one cycle after space frees.
  always_comb begin
    credit_used = data_t'(fifo_count) + data_t'(col_vld_q);
    issue       = (idx_q < bus.csize) && (credit_used < data_t'(V_SIZE));
    idx_d       = idx_q;
    col_reg_d   = col_reg_q;
    col_vld_d   = 1'b0;
    if (issue) begin
      idx_d     = idx_q + 1'b1;
      col_reg_d = bus.dataIn1;
      col_vld_d = 1'b1;
    end
    done_d = done_q | ((idx_d == bus.csize) && !col_vld_d);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      idx_q     <= '0;
      col_reg_q <= '0;
      col_vld_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      col_reg_q <= col_reg_d;
      col_vld_q <= col_vld_d;
      done_q    <= done_d;
    end
  end

  assign bus.addr1 = bus.wdata_col_base + idx_q;
  assign bus.addr2 = bus.v_values_base + col_reg_q;
  assign bus.valid = !fifo_empty;
  assign bus.full  = fifo_full;
  assign bus.done  = done_q;

  hht_vfifo #(
    .DEPTH (V_SIZE),
    .WIDTH (DW)
  ) u_vfifo (
    .clk       (Clk),
    .rst       (Rst),
    .push      (col_vld_q),
    .push_data (bus.dataIn2),
    .pop       (bus.RD),
    .data_out  (bus.dataOut),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_hht_control.sv
// Self-checking bench for hht_control: model memories, scoreboard of expected
// gathered values, and directed scenarios for streaming, backpressure and reset.
module tb_hht_control;
  import hht_pkg::*;

  localparam int V_BASE = 2;
  localparam int C_BASE = 340;
  localparam int N_COLS = 205;

  logic clk;
  logic rst;
  int   edge_n;
  int   tests_run;
  int   fail_count;
  int   pops;
  int   target;
  logic full_seen;
  logic valid_seen;
  logic saw_oob;
  logic col_override;
  data_t last_data;
  data_t exp_q[$];
  data_t col_arr [N_COLS];
  data_t vec_arr [32];

  hht_control_if bus ();

  hht_control #(.V_SIZE(9)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge number since reset release: after edge e is seen, edge_n == e.
  always @(posedge clk) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  function automatic data_t col_read(input data_t a);
    if (col_override && a == 32'd343) return 32'd99999;
    if (a >= 32'd340 && a <= 32'd544) return col_arr[a - 32'd340];
    return 32'd99999;
  endfunction

  function automatic data_t vec_read(input data_t a);
    if (a >= 32'd2 && a <= 32'd33) return vec_arr[a - 32'd2];
    return 32'd99999;
  endfunction

  assign bus.dataIn1 = col_read(bus.addr1);
  assign bus.dataIn2 = vec_read(bus.addr2);

  task automatic checkOutput(input string tag, input data_t actual, input data_t expected);
    tests_run++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Expected results are derived from the model memories as the stream is set up.
  task automatic load_expected(input int n);
    data_t base_c;
    data_t base_v;
    exp_q.delete();
    base_c = bus.wdata_col_base;
    base_v = bus.v_values_base;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(vec_read(base_v + col_read(base_c + data_t'(i))));
    end
    pops       = 0;
    target     = n;
    full_seen  = 1'b0;
    valid_seen = 1'b0;
    saw_oob    = 1'b0;
  endtask

  // One cycle: drive RD for the coming edge and score any pop it will perform.
  task automatic applyStimulus(input logic rd_val);
    data_t exp_v;
    @(negedge clk);
    bus.RD = rd_val;
    if (bus.full)  full_seen  = 1'b1;
    if (bus.valid) valid_seen = 1'b1;
    if (bus.addr2 == 32'd100001) saw_oob = 1'b1;
    if (bus.valid && rd_val) begin
      if (exp_q.size() == 0) begin
        checkOutput("extra_pop", bus.dataOut, 32'hFFFF_FFFF);
      end else begin
        exp_v = exp_q.pop_front();
        checkOutput("data", bus.dataOut, exp_v);
        last_data = bus.dataOut;
        pops++;
      end
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    bus.RD = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_until_drained(input int budget);
    int n = 0;
    while ((pops < target || !bus.done) && n < budget) begin
      applyStimulus(1'b1);
      n++;
    end
    if (n >= budget) checkOutput("drain_timeout", data_t'(n), data_t'(budget - 1));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tests_run    = 0;
    fail_count   = 0;
    col_override = 1'b0;
    last_data    = '0;
    for (int i = 0; i < N_COLS; i++) col_arr[i] = data_t'((i * 7 + 3) % 32);
    col_arr[0] = 15; col_arr[1] = 1; col_arr[2] = 9; col_arr[3] = 8; col_arr[4] = 31;
    col_arr[204] = 11;
    for (int k = 0; k < 32; k++) vec_arr[k] = data_t'(1000 + k * 3);
    vec_arr[17 - 2] = 32; vec_arr[3 - 2] = 16; vec_arr[11 - 2] = 93;
    vec_arr[10 - 2] = 98; vec_arr[33 - 2] = 65; vec_arr[13 - 2] = 71;

    bus.v_values_base  = V_BASE;
    bus.wdata_col_base = C_BASE;
    bus.csize          = N_COLS;
    bus.RD             = 1'b0;

    // Reset values
    do_reset();
    checkOutput("rst_valid", data_t'(bus.valid), 0);
    checkOutput("rst_full", data_t'(bus.full), 0);
    checkOutput("rst_done", data_t'(bus.done), 0);
    checkOutput("rst_addr1", bus.addr1, 340);
    checkOutput("rst_addr2", bus.addr2, 2);
    checkOutput("rst_dataout", bus.dataOut, 0);

    // Full stream with RD held high
    load_expected(N_COLS);
    bus.RD = 1'b1;
    rst    = 1'b0;
    while (edge_n < 210) begin
      applyStimulus(1'b1);
      if (edge_n == 1)   checkOutput("valid_e1", data_t'(bus.valid), 0);
      if (edge_n == 2)   checkOutput("valid_e2", data_t'(bus.valid), 1);
      if (edge_n == 2)   checkOutput("first_e2", bus.dataOut, 32);
      if (edge_n == 205) checkOutput("done_e205", data_t'(bus.done), 0);
      if (edge_n == 206) checkOutput("done_e206", data_t'(bus.done), 1);
    end
    checkOutput("stream_pops", data_t'(pops), N_COLS);
    checkOutput("stream_left", data_t'(exp_q.size()), 0);
    checkOutput("stream_last", last_data, 71);
    checkOutput("stream_full", data_t'(full_seen), 0);

    // Backpressure: RD low until the FIFO fills, then drain
    do_reset();
    load_expected(N_COLS);
    rst = 1'b0;
    while (edge_n < 14) begin
      applyStimulus(1'b0);
      if (edge_n == 9)  checkOutput("bp_full_e9", data_t'(bus.full), 0);
      if (edge_n == 9)  checkOutput("bp_addr1_e9", bus.addr1, 349);
      if (edge_n == 10) checkOutput("bp_full_e10", data_t'(bus.full), 1);
      if (edge_n == 10) checkOutput("bp_addr1_e10", bus.addr1, 349);
    end
    checkOutput("bp_full_hold", data_t'(bus.full), 1);
    checkOutput("bp_addr1_hold", bus.addr1, 349);
    checkOutput("bp_head", bus.dataOut, 32);
    checkOutput("bp_done_hold", data_t'(bus.done), 0);
    run_until_drained(400);
    checkOutput("bp_pops", data_t'(pops), N_COLS);
    checkOutput("bp_left", data_t'(exp_q.size()), 0);

    // Reset in the middle of a stream, then restart from the beginning
    do_reset();
    load_expected(N_COLS);
    rst = 1'b0;
    while (pops < 50 && edge_n < 100) applyStimulus(1'b1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_valid", data_t'(bus.valid), 0);
    checkOutput("mid_addr1", bus.addr1, 340);
    checkOutput("mid_addr2", bus.addr2, 2);
    checkOutput("mid_done", data_t'(bus.done), 0);
    load_expected(N_COLS);
    rst = 1'b0;
    run_until_drained(300);
    checkOutput("mid_pops", data_t'(pops), N_COLS);
    checkOutput("mid_last", last_data, 71);

    // Empty job
    do_reset();
    bus.csize = 0;
    load_expected(0);
    rst = 1'b0;
    applyStimulus(1'b1);
    checkOutput("zero_done_e1", data_t'(bus.done), 1);
    repeat (5) applyStimulus(1'b1);
    checkOutput("zero_valid", data_t'(valid_seen), 0);
    checkOutput("zero_addr1", bus.addr1, 340);

    // Out-of-range index passes garbage through unmodified
    do_reset();
    col_override = 1'b1;
    bus.csize    = 6;
    load_expected(6);
    rst = 1'b0;
    run_until_drained(100);
    checkOutput("oob_addr2", data_t'(saw_oob), 1);
    checkOutput("oob_pops", data_t'(pops), 6);
    col_override = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/hht_control.md
# hht_control

Gather front-end of the HHT sparse-matrix helper.
- Streams `csize` column indices from column-index memory (port 1), starting at `wdata_col_base`.
- Uses each index to fetch the matching vector element from value memory (port 2), based at `v_values_base`.
- Queues the gathered values in a `V_SIZE`-deep FIFO that the consumer drains with `RD`.
- Sits between the two combinational-read memories and the multiply/accumulate consumer.

## Interface
- V_SIZE, 9, FIFO depth in entries.
- DW, 32, data and address width.
- Clk  in  1  single clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- v_values_base  in  32  word address of vector element 0; held stable while running.
- wdata_col_base  in  32  word address of column index 0; held stable while running.
- addr1  out  32  column-index memory address.
- addr2  out  32  vector memory address.
- dataIn1  in  32  column index read combinationally at addr1, same cycle.
- dataIn2  in  32  vector value read combinationally at addr2, same cycle.
- csize  in  32  number of column indices (non-zeros) to process; held stable while running.
- RD  in  1  consumer pop request.
- dataOut  out  32  FIFO head; 0 when empty.
- valid  out  1  FIFO non-empty.
- full  out  1  FIFO holds V_SIZE entries.
- done  out  1  all csize values pushed; sticky until Rst.

## Operation
- Stage A (issue):
  - addr1 = wdata_col_base + idx, where idx is a 32-bit counter.
  - Issue condition: idx < csize and (count + col_vld) < V_SIZE. count is the FIFO occupancy. The condition deliberately ignores a same-cycle pop.
  - On issue: col_reg <= dataIn1, col_vld <= 1, idx <= idx + 1.
  - Otherwise: col_vld <= 0, and idx and col_reg hold.
- Stage B (gather):
  - addr2 = v_values_base + col_reg.
  - If col_vld, push dataIn2 into the FIFO at the edge.
  - Issue credit guarantees the FIFO never overflows.
- FIFO:
  - Pop when RD && valid. RD on an empty FIFO is ignored.
  - Push and pop in the same cycle leaves count unchanged and keeps FIFO order.
- Address arithmetic: modulo 2^32, no range checking. Whatever the memory returns (including default/garbage words) is passed through unmodified.
- done <= 1 once idx == csize and col_vld == 0. It does not wait for the FIFO to drain.
- csize == 0: nothing is issued, and done rises on the first edge after Rst deasserts.
- Rst mid-operation: all progress and FIFO contents are discarded, and processing restarts from idx 0.
- Reset values:
  - idx 0, col_reg 0, col_vld 0, count 0, done 0.
  - Hence addr1 = wdata_col_base, addr2 = v_values_base, dataOut 0, valid 0, full 0.

## Timing
- Throughput: one element per cycle while the FIFO has credit.
- Latency: an index issued at edge N is pushed at edge N+1 and is visible on dataOut/valid after edge N+1 if the FIFO was empty.
- After Rst falls, the first element is issued at edge 1 and valid rises after edge 2.
- With RD held high, occupancy stays at 1 or less in steady state, and done rises after edge csize+1.
- With RD low, the FIFO fills to V_SIZE (full=1) and issue stalls. addr1 holds at the next index. Issue resumes the cycle after a pop frees credit.

## Structure
- Shared package `hht_pkg`: DW, default V_SIZE, data/address typedefs.
- One sub-module `hht_vfifo`: parameterised synchronous FIFO (push, pop, dataOut, count, full, empty), reset by Rst.
- Index counter, stage register and credit logic live in hht_control.

## Test plan
- Bench drives v_values_base=2, wdata_col_base=340, csize=205.
  - Column memory: 340→15, 341→1, 342→9, 343→8, 344→31, …, 544→11.
  - Vector memory: 2..33, with addr 17→32, 3→16, 11→93, 10→98, 33→65, 13→71.
  - Memory words outside 2..33 and 340..544 return 99999.
- Full stream, RD=1: dataOut sequence 32, 16, 93, 98, 65, …, last 71. Exactly 205 pops; done=1 after edge 206; the FIFO never exceeds 1 entry.
- Backpressure, RD=0: full rises after edge 10 with 9 entries, and addr1 holds at 349. Raising RD resumes the stream with no loss or duplication.
- Reset at element 50: valid=0, addr1=340, addr2=2, done=0. The stream restarts at 32.
- csize=0: done=1 one edge after reset release; valid never asserts.
- Out-of-range index: an index word of 99999 makes addr2 = 100001, and the value 99999 is pushed unchanged.
